alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 259 +++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with single-cycle arithmetic/logic/shift ops, radix-2 Booth
// multiplier and an optional signed restoring divider enabled by defining ALU_SEQ_DIV_EN.
module alu_seq #(
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          clear,
    input  logic          start,
    input  logic [3:0]    op,
    input  logic [DW-1:0] A,
    input  logic [DW-1:0] B,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] LO,
    output logic [DW-1:0] HI,
    output logic          div_zero,
    output logic          illegal_op
);

    localparam int SW = $clog2(DW);
    localparam int CW = SW + 1;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_NEG = 4'b0110;
    localparam logic [3:0] OP_NOT = 4'b0111;
    localparam logic [3:0] OP_LSR = 4'b1000;
    localparam logic [3:0] OP_LSL = 4'b1001;
    localparam logic [3:0] OP_RL  = 4'b1010;
    localparam logic [3:0] OP_RR  = 4'b1011;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIN  = 2'b10
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    op_q;
    logic [DW-1:0] a_q;
    logic [DW-1:0] b_q;
    logic [DW:0]   acc_q;
    logic [DW-1:0] mq_q;
    logic          q1_q;
    logic [DW-1:0] lo_q;
    logic [DW-1:0] hi_q;
    logic          busy_q;
    logic          done_q;
    logic          ill_q;

    logic [SW-1:0] shamt_s;
    logic [DW-1:0] alu_lo_d;
    logic [DW:0]   m_ext_s;
    logic [DW:0]   booth_sum_s;
    logic [DW:0]   booth_acc_d;
    logic [DW-1:0] booth_mq_d;

    function automatic logic [DW-1:0] rot_left(input logic [DW-1:0] v, input logic [SW-1:0] s);
        logic [2*DW-1:0] t;
        t = {v, v} << s;
        return t[2*DW-1:DW];
    endfunction

    function automatic logic [DW-1:0] rot_right(input logic [DW-1:0] v, input logic [SW-1:0] s);
        logic [2*DW-1:0] t;
        t = {v, v} >> s;
        return t[DW-1:0];
    endfunction

    assign shamt_s = b_q[SW-1:0];
    assign m_ext_s = {a_q[DW-1], a_q};

    // Single-cycle result from the latched operands.
    always_comb begin
        alu_lo_d = lo_q;
        case (op_q)
            OP_ADD:  alu_lo_d = a_q + b_q;
            OP_SUB:  alu_lo_d = a_q - b_q;
            OP_AND:  alu_lo_d = a_q & b_q;
            OP_OR:   alu_lo_d = a_q | b_q;
            OP_NEG:  alu_lo_d = {DW{1'b0}} - b_q;
            OP_NOT:  alu_lo_d = ~b_q;
            OP_LSR:  alu_lo_d = a_q >> shamt_s;
            OP_LSL:  alu_lo_d = a_q << shamt_s;
            OP_RL:   alu_lo_d = rot_left(a_q, shamt_s);
            OP_RR:   alu_lo_d = rot_right(a_q, shamt_s);
            default: alu_lo_d = lo_q;
        endcase
    end

    // One Booth step; the extra accumulator bit absorbs the most-negative multiplicand.
    always_comb begin
        case ({mq_q[0], q1_q})
            2'b01:   booth_sum_s = acc_q + m_ext_s;
            2'b10:   booth_sum_s = acc_q - m_ext_s;
            default: booth_sum_s = acc_q;
        endcase
        booth_acc_d = {booth_sum_s[DW], booth_sum_s[DW:1]};
        booth_mq_d  = {booth_sum_s[0], mq_q[DW-1:1]};
    end

`ifdef ALU_SEQ_DIV_EN
    logic [DW-1:0] dvs_q;
    logic          divz_q;
    logic [DW-1:0] abs_a_s;
    logic [DW-1:0] abs_b_s;
    logic [DW:0]   div_shift_s;
    logic [DW:0]   div_trial_s;
    logic [DW:0]   div_acc_d;
    logic [DW-1:0] div_mq_d;
    logic [DW-1:0] div_quo_s;
    logic [DW-1:0] div_rem_s;

    assign abs_a_s = A[DW-1] ? (~A + {{(DW-1){1'b0}}, 1'b1}) : A;
    assign abs_b_s = B[DW-1] ? (~B + {{(DW-1){1'b0}}, 1'b1}) : B;

    // Unsigned restoring step on magnitudes, then sign fix-up of quotient and remainder.
    always_comb begin
        div_shift_s = {acc_q[DW-1:0], mq_q[DW-1]};
        div_trial_s = div_shift_s - {1'b0, dvs_q};
        if (!div_trial_s[DW]) begin
            div_acc_d = div_trial_s;
            div_mq_d  = {mq_q[DW-2:0], 1'b1};
        end else begin
            div_acc_d = div_shift_s;
            div_mq_d  = {mq_q[DW-2:0], 1'b0};
        end
        if (a_q[DW-1] ^ b_q[DW-1]) begin
            div_quo_s = {DW{1'b0}} - mq_q;
        end else begin
            div_quo_s = mq_q;
        end
        if (a_q[DW-1]) begin
            div_rem_s = {DW{1'b0}} - acc_q[DW-1:0];
        end else begin
            div_rem_s = acc_q[DW-1:0];
        end
    end

    assign div_zero = divz_q;
`else
    assign div_zero = 1'b0;
`endif

    // Control FSM, operand latches, iteration datapath and registered results.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_IDLE;
            cnt_q   <= {CW{1'b0}};
            op_q    <= 4'b0000;
            a_q     <= {DW{1'b0}};
            b_q     <= {DW{1'b0}};
            acc_q   <= {(DW+1){1'b0}};
            mq_q    <= {DW{1'b0}};
            q1_q    <= 1'b0;
            lo_q    <= {DW{1'b0}};
            hi_q    <= {DW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ill_q   <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            dvs_q   <= {DW{1'b0}};
            divz_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            ill_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        a_q    <= A;
                        b_q    <= B;
                        cnt_q  <= {CW{1'b0}};
                        busy_q <= 1'b1;
                        if (op == OP_MUL) begin
                            acc_q   <= {(DW+1){1'b0}};
                            mq_q    <= B;
                            q1_q    <= 1'b0;
                            state_q <= S_RUN;
                        end
`ifdef ALU_SEQ_DIV_EN
                        else if ((op == OP_DIV) && (B != {DW{1'b0}})) begin
                            acc_q   <= {(DW+1){1'b0}};
                            mq_q    <= abs_a_s;
                            dvs_q   <= abs_b_s;
                            divz_q  <= 1'b0;
                            state_q <= S_RUN;
                        end
`endif
                        else begin
                            state_q <= S_FIN;
                        end
                    end
                end
                S_RUN: begin
                    case (op_q)
                        OP_MUL: begin
                            acc_q <= booth_acc_d;
                            mq_q  <= booth_mq_d;
                            q1_q  <= mq_q[0];
                        end
`ifdef ALU_SEQ_DIV_EN
                        OP_DIV: begin
                            acc_q <= div_acc_d;
                            mq_q  <= div_mq_d;
                        end
`endif
                        default: acc_q <= acc_q;
                    endcase
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(DW - 1)) begin
                        state_q <= S_FIN;
                    end
                end
                S_FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    cnt_q   <= {CW{1'b0}};
                    state_q <= S_IDLE;
                    case (op_q)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NEG, OP_NOT,
                        OP_LSR, OP_LSL, OP_RL, OP_RR: lo_q <= alu_lo_d;
                        OP_MUL: {hi_q, lo_q} <= {acc_q[DW-1:0], mq_q};
`ifdef ALU_SEQ_DIV_EN
                        OP_DIV: begin
                            if (b_q == {DW{1'b0}}) begin
                                lo_q   <= {DW{1'b1}};
                                hi_q   <= a_q;
                                divz_q <= 1'b1;
                            end else begin
                                lo_q <= div_quo_s;
                                hi_q <= div_rem_s;
                            end
                        end
`endif
                        default: ill_q <= 1'b1;
                    endcase
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign LO         = lo_q;
    assign HI         = hi_q;
    assign illegal_op = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed corner cases plus random ops against an
// arithmetic reference model; honours ALU_SEQ_DIV_EN the same way as the design.
module tb_alu_seq;

    localparam int DW = 32;

    logic          clock;
    logic          clear;
    logic          start;
    logic [3:0]    op;
    logic [DW-1:0] A;
    logic [DW-1:0] B;
    logic          busy;
    logic          done;
    logic [DW-1:0] LO;
    logic [DW-1:0] HI;
    logic          div_zero;
    logic          illegal_op;

    int n_assert;
    int n_fail;

    logic [DW-1:0] exp_lo;
    logic [DW-1:0] exp_hi;
    logic          exp_dz;
    logic          exp_ill;
    int            exp_lat;

    alu_seq #(.DW(DW)) dut (
        .clock      (clock),
        .clear      (clear),
        .start      (start),
        .op         (op),
        .A          (A),
        .B          (B),
        .busy       (busy),
        .done       (done),
        .LO         (LO),
        .HI         (HI),
        .div_zero   (div_zero),
        .illegal_op (illegal_op)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: the architectural effect of one operation, in plain arithmetic.
    task automatic model_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        longint prod;
        longint q;
        longint r;
        int     s;
        s       = int'(b % 32);
        exp_ill = 1'b0;
        exp_lat = 2;
        case (o)
            4'd0: exp_lo = a + b;
            4'd1: exp_lo = a - b;
            4'd2: begin
                prod    = longint'($signed(a)) * longint'($signed(b));
                exp_hi  = prod[63:32];
                exp_lo  = prod[31:0];
                exp_lat = DW + 2;
            end
`ifdef ALU_SEQ_DIV_EN
            4'd3: begin
                if (b == 32'd0) begin
                    exp_lo = 32'hFFFF_FFFF;
                    exp_hi = a;
                    exp_dz = 1'b1;
                end else begin
                    q       = longint'($signed(a)) / longint'($signed(b));
                    r       = longint'($signed(a)) % longint'($signed(b));
                    exp_lo  = q[31:0];
                    exp_hi  = r[31:0];
                    exp_dz  = 1'b0;
                    exp_lat = DW + 2;
                end
            end
`endif
            4'd4: exp_lo = a & b;
            4'd5: exp_lo = a | b;
            4'd6: exp_lo = 32'd0 - b;
            4'd7: exp_lo = ~b;
            4'd8: exp_lo = a >> s;
            4'd9: exp_lo = a << s;
            4'd10: exp_lo = (s == 0) ? a : ((a << s) | (a >> (32 - s)));
            4'd11: exp_lo = (s == 0) ? a : ((a >> s) | (a << (32 - s)));
            default: exp_ill = 1'b1;
        endcase
    endtask

    // Issue one op, scramble inputs (and fire stray starts) while busy, then check.
    task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int inj);
        int edges;
        int bcnt;
        int extra;
        bit got;
        model_op(o, a, b);
        @(negedge clock);
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clock);
        #1;
        start = 1'b0; op = 4'($urandom); A = $urandom; B = $urandom;
        edges = 0; bcnt = 0; got = 1'b0;
        @(negedge clock);
        while (!got && edges < 200) begin
            if (done) begin
                got   = 1'b1;
                start = 1'b0;
            end else begin
                if (busy) bcnt++;
                op = 4'($urandom); A = $urandom; B = $urandom;
                start = busy && ($urandom_range(0, 3) == 0);
                if (edges == inj) begin
                    start = 1'b1; op = 4'd0; A = 32'd1; B = 32'd1;
                end
                @(posedge clock);
                edges++;
                @(negedge clock);
            end
        end
        check("latency", got ? 64'(edges + 1) : 64'hFFFF, 64'(exp_lat));
        check("busy_cycles", 64'(bcnt), 64'(exp_lat - 1));
        check("LO", 64'(LO), 64'(exp_lo));
        check("HI", 64'(HI), 64'(exp_hi));
        check("illegal_op", 64'(illegal_op), 64'(exp_ill));
        check("div_zero", 64'(div_zero), 64'(exp_dz));
        extra = 0;
        repeat (3) begin
            @(negedge clock);
            if (done) extra++;
        end
        check("single_done", 64'(extra), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [3:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          nd;
        n_assert = 0; n_fail = 0;
        clock = 1'b0; clear = 1'b0; start = 1'b0; op = 4'd0; A = 32'd0; B = 32'd0;
        exp_lo = 32'd0; exp_hi = 32'd0; exp_dz = 1'b0; exp_ill = 1'b0; exp_lat = 2;

        #1;
        check("rst_LO", 64'(LO), 64'd0);
        check("rst_HI", 64'(HI), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dz", 64'(div_zero), 64'd0);
        check("rst_ill", 64'(illegal_op), 64'd0);
        #20;
        @(negedge clock);
        clear = 1'b1;

        do_op(4'd0, 32'h7FFF_FFFF, 32'd1, -1);
        do_op(4'd2, 32'hFFFF_FFFD, 32'd7, -1);
`ifdef ALU_SEQ_DIV_EN
        do_op(4'd3, 32'hFFFF_FFF9, 32'd2, -1);
        do_op(4'd3, 32'd5, 32'd0, -1);
        do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        do_op(4'd3, 32'd100, 32'hFFFF_FFF9, -1);
`else
        do_op(4'd3, 32'd9, 32'd3, -1);
`endif
        do_op(4'd2, 32'd12345, 32'hFFFF_0001, 10);
        do_op(4'd12, 32'd1, 32'd2, -1);
        do_op(4'd2, 32'h8000_0000, 32'h8000_0000, -1);

        // Reset in the middle of a multiply.
        @(negedge clock);
        start = 1'b1; op = 4'd2; A = 32'd99; B = 32'd77;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clock);
        #2;
        clear = 1'b0;
        #1;
        check("mid_rst_LO", 64'(LO), 64'd0);
        check("mid_rst_HI", 64'(HI), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        exp_lo = 32'd0; exp_hi = 32'd0; exp_dz = 1'b0;
        @(negedge clock);
        clear = 1'b1;
        nd = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) nd++;
        end
        check("no_done_after_rst", 64'(nd), 64'd0);
        do_op(4'd0, 32'd2, 32'd3, -1);

        for (int i = 0; i < 40; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = pick();
            rb = pick();
            if (ro == 4'd3 && $urandom_range(0, 3) == 0) rb = 32'd0;
            do_op(ro, ra, rb, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
